// File: rtl/adc_capture_writer.sv
`default_nettype none
// ============================================================================
// adc_capture_writer : triggered, decimated ADC block capture into a RAM
// Revision: 1.0
// ============================================================================
module adc_capture_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ad_data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic [DIV_WIDTH-1:0]  decim,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  triggered
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] TM_IMM  = 2'b00;
  localparam logic [1:0] TM_RISE = 2'b01;
  localparam logic [1:0] TM_FALL = 2'b10;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic [DIV_WIDTH-1:0]  decim_q, decim_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  force_pend_q, force_pend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  triggered_q, triggered_d;

  logic running, tick, rise_hit, fall_hit, trig_hit;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    level_d      = level_q;
    decim_d      = decim_q;
    div_cnt_d    = '0;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    triggered_d  = 1'b0;
    tick         = 1'b0;

    running  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    rise_hit = prev_valid_q && (prev_q < level_q) && (ad_data >= level_q);
    fall_hit = prev_valid_q && (prev_q > level_q) && (ad_data <= level_q);
    case (mode_q)
      TM_IMM:  trig_hit = 1'b1;
      TM_RISE: trig_hit = rise_hit;
      TM_FALL: trig_hit = fall_hit;
      default: trig_hit = rise_hit || fall_hit;
    endcase

    if (running) begin
      tick      = (div_cnt_q == decim_q);
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    if (tick) begin
      prev_d       = ad_data;
      prev_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d      = S_ARMED;
          mode_d       = trig_mode;
          level_d      = trig_level;
          decim_d      = decim;
          prev_valid_d = 1'b0;
          force_pend_d = 1'b0;
        end
      end
      S_ARMED: begin
        // A pulsed force must survive until the next decimated tick.
        if (force_trig) force_pend_d = 1'b1;
        if (tick && (trig_hit || force_trig || force_pend_q)) begin
          state_d      = S_CAPTURE;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = ad_data;
          cnt_d        = (ADDR_WIDTH+1)'(1);
          triggered_d  = 1'b1;
          force_pend_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
          wr_data_d = ad_data;
          cnt_d     = cnt_q + (ADDR_WIDTH+1)'(1);
          if (cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      triggered_d  = 1'b0;
      force_pend_d = 1'b0;
      div_cnt_d    = '0;
    end

    busy_d = running;
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      level_q      <= '0;
      decim_q      <= '0;
      div_cnt_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      triggered_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      decim_q      <= decim_d;
      div_cnt_q    <= div_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      triggered_q  <= triggered_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign triggered = triggered_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_writer.sv
`default_nettype none
// ============================================================================
// tb_adc_capture_writer : directed bench for adc_capture_writer
// Revision: 1.0
// ============================================================================
module tb_adc_capture_writer;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ad_data;
  logic        arm, abort, force_trig;
  logic [1:0]  trig_mode;
  logic [7:0]  trig_level;
  logic [15:0] decim;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, triggered;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int src_mode = 0;
  logic [7:0] sine [64];

  adc_capture_writer #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .arm(arm), .abort(abort),
    .force_trig(force_trig), .trig_mode(trig_mode), .trig_level(trig_level),
    .decim(decim), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .triggered(triggered)
  );

  always #5 clk = ~clk;

  // Sample source indexed by cycle number: 0 ramp, 1 sine, 2 constant 0x20.
  function automatic logic [7:0] gen(input int c);
    case (src_mode)
      0:       gen = c[7:0];
      1:       gen = sine[c % 64];
      default: gen = 8'h20;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
    arm        = 1'b0;
    abort      = 1'b0;
    force_trig = 1'b0;
    ad_data    = gen(cyc);
  endtask

  // Follows one capture: write k must carry sample gen(first_idx+k*period)
  // and appear at cycle first_idx+1+k*period.
  task automatic run_cap(input string tag, input int first_idx, input int period,
                         input int limit, input int budget, input int arm_at);
    int nwr   = 0;
    int n     = 0;
    int ntrig = 0;
    while (nwr < limit && n < budget) begin
      clk1();
      n++;
      if (triggered) ntrig++;
      if (wr_en) begin
        chk({tag, " addr"}, 32'(wr_addr), nwr);
        chk({tag, " data"}, 32'(wr_data), 32'(gen(first_idx + nwr*period)));
        chk({tag, " time"}, cyc, first_idx + 1 + nwr*period);
        nwr++;
        if (nwr == arm_at) arm = 1'b1;
      end
    end
    chk({tag, " writes"}, nwr, limit);
    chk({tag, " trig pulses"}, ntrig, 1);
    if (limit == DEPTH) begin
      clk1();
      chk({tag, " done"}, 32'(done), 1);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " wr_en after"}, 32'(wr_en), 0);
    end
  endtask

  initial begin
    int a, j, f, nw;
    for (int i = 0; i < 64; i++)
      sine[i] = 8'($rtoi(128.0 + 100.0 * $sin(6.283185307 * i / 64.0)));
    rst = 1'b1; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    trig_mode = 2'b00; trig_level = 8'h00; decim = 16'd0;
    ad_data = gen(0);
    repeat (3) clk1();
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst wr_data", 32'(wr_data), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst triggered", 32'(triggered), 0);
    rst = 1'b0;
    clk1();

    // Immediate, no decimation, ramp.
    arm = 1'b1; a = cyc;
    run_cap("imm", a + 1, 1, DEPTH, 1200, -1);

    // Decimate by 4; decim input changed after arm must be ignored.
    decim = 16'd3; arm = 1'b1; a = cyc;
    clk1();
    decim = 16'd9;
    run_cap("dec3", a + 4, 4, DEPTH, 4300, -1);

    // Rising edge through 0x80 on a sine.
    src_mode = 1; trig_mode = 2'b01; trig_level = 8'h80; decim = 16'd0;
    clk1();
    arm = 1'b1; a = cyc;
    j = a + 2;
    while (!(gen(j - 1) < 8'h80 && gen(j) >= 8'h80)) j++;
    run_cap("rise", j, 1, DEPTH, 1300, -1);

    // Falling on a constant below level never fires; force_trig does.
    src_mode = 2; trig_mode = 2'b10; trig_level = 8'h40;
    clk1();
    arm = 1'b1;
    clk1();
    nw = 0;
    repeat (5000) begin
      clk1();
      if (wr_en || triggered) nw++;
    end
    chk("stall writes", nw, 0);
    chk("stall busy", 32'(busy), 1);
    force_trig = 1'b1; f = cyc;
    run_cap("force", f, 1, DEPTH, 1200, -1);

    // Abort at write #500 together with arm.
    src_mode = 0; trig_mode = 2'b00;
    clk1();
    arm = 1'b1; a = cyc;
    run_cap("pre-abort", a + 1, 1, 500, 700, -1);
    abort = 1'b1; arm = 1'b1;
    clk1();
    chk("abort no write", 32'(wr_en), 0);
    clk1();
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort wr_en", 32'(wr_en), 0);
    nw = 0;
    repeat (20) begin
      clk1();
      if (wr_en || busy) nw++;
    end
    chk("abort idle", nw, 0);
    arm = 1'b1; a = cyc;
    run_cap("rearm", a + 1, 1, DEPTH, 1200, -1);

    // Reset mid-capture, then capture with an ignored arm while busy.
    arm = 1'b1; a = cyc;
    run_cap("pre-rst", a + 1, 1, 300, 400, -1);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("midrst wr_en", 32'(wr_en), 0);
    chk("midrst wr_addr", 32'(wr_addr), 0);
    chk("midrst wr_data", 32'(wr_data), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst triggered", 32'(triggered), 0);
    clk1();
    chk("postrst idle wr_en", 32'(wr_en), 0);
    chk("postrst idle busy", 32'(busy), 0);
    arm = 1'b1; a = cyc;
    run_cap("post-rst", a + 1, 1, DEPTH, 1200, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
